// File: rtl/fetch_queue.sv
// Instruction fetch buffer: an in-order FIFO of {PC, PC+4, instruction} triples between fetch
// and decode, with a valid/ready handshake on both sides and a synchronous redirect flush.
module fetch_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_pcplus4,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_pcplus4,
  output logic [WIDTH-1:0]         out_instr,
  output logic                     out_misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcplus4;
    logic [WIDTH-1:0] instr;
    logic             misalign;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Handshake flags come only from the registered count, so there is no in->out path.
  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      // Storage is left intact; only the pointers and occupancy are discarded.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc:       in_pc,
                            pcplus4:  in_pcplus4,
                            instr:    in_instr,
                            misalign: |in_pc[1:0]};
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign out_pc       = mem_q[rd_ptr_q].pc;
  assign out_pcplus4  = mem_q[rd_ptr_q].pcplus4;
  assign out_instr    = mem_q[rd_ptr_q].instr;
  assign out_misalign = mem_q[rd_ptr_q].misalign;
  assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset check, a vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_pc;
  logic [W-1:0]  in_pcplus4;
  logic [W-1:0]  in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_pc;
  logic [W-1:0]  out_pcplus4;
  logic [W-1:0]  out_instr;
  logic          out_misalign;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_pcplus4  (in_pcplus4),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pcplus4 (out_pcplus4),
    .out_instr   (out_instr),
    .out_misalign(out_misalign),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    int          cnt;
    logic        ir;
    logic        ov;
    logic        chk_pc;
    logic [31:0] opc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] instr;
  } ent_t;

  vec_t vecs[12];
  ent_t model[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy);
    in_valid   = iv;
    in_pc      = pc;
    in_pcplus4 = pc + 32'd4;
    in_instr   = instr_of(pc);
    out_ready  = ordy;
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic ordy,
                              input logic [31:0] pc, input int cnt, input logic ir,
                              input logic ov, input logic chk_pc, input logic [31:0] opc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.cnt = cnt;
    v.ir = ir; v.ov = ov; v.chk_pc = chk_pc; v.opc = opc;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_out;
    logic [31:0] nxt;
    logic        acc;
    logic        m_ir, m_ov;

    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) step();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_pc", out_pc, 32'd0);
    chk("reset_misalign", 32'(out_misalign), 32'd0);
    rst = 1'b1;
    step();

    // Fill, reject when full, pop with simultaneous rejected push, then drain.
    vecs[0]  = mk(0, 1, 0, 32'h00, 1, 1, 1, 1, 32'h00);
    vecs[1]  = mk(0, 1, 0, 32'h04, 2, 1, 1, 1, 32'h00);
    vecs[2]  = mk(0, 1, 0, 32'h08, 3, 1, 1, 1, 32'h00);
    vecs[3]  = mk(0, 1, 0, 32'h0C, 4, 0, 1, 1, 32'h00);
    vecs[4]  = mk(0, 1, 0, 32'h10, 4, 0, 1, 1, 32'h00);
    vecs[5]  = mk(0, 1, 1, 32'h10, 3, 1, 1, 1, 32'h04);
    vecs[6]  = mk(0, 1, 0, 32'h10, 4, 0, 1, 1, 32'h04);
    vecs[7]  = mk(0, 1, 1, 32'h14, 3, 1, 1, 1, 32'h08);
    vecs[8]  = mk(0, 0, 1, 32'h00, 2, 1, 1, 1, 32'h0C);
    vecs[9]  = mk(0, 0, 1, 32'h00, 1, 1, 1, 1, 32'h10);
    vecs[10] = mk(0, 1, 1, 32'h18, 1, 1, 1, 1, 32'h18);
    vecs[11] = mk(0, 0, 1, 32'h00, 0, 1, 0, 0, 32'h00);
    for (int i = 0; i < 12; i++) begin
      flush = vecs[i].fl;
      drive(vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].chk_pc) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].opc);
        chk($sformatf("vec%0d_out_pcplus4", i), out_pcplus4, vecs[i].opc + 32'd4);
      end
    end

    // Refill, then stream with continuous push/pop across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0);
      step();
    end
    chk("refill_count", 32'(count), 32'd4);
    exp_out = 32'h00;
    nxt     = 32'h10;
    for (int it = 0; it < 20 && nxt != 32'h38; it++) begin
      drive(1'b1, nxt, 1'b1);
      chk($sformatf("stream%0d_out_pc", it), out_pc, exp_out);
      chk($sformatf("stream%0d_out_instr", it), out_instr, instr_of(exp_out));
      acc = in_ready;
      step();
      exp_out = exp_out + 32'd4;
      if (acc) nxt = nxt + 32'd4;
    end
    chk("stream_all_pushed", nxt, 32'h38);
    drive(1'b0, 32'h0, 1'b0);
    chk("stream_count", 32'(count), 32'd3);
    chk("stream_head", out_pc, exp_out);

    // Flush with concurrent push and pop at count=3.
    flush = 1'b1;
    drive(1'b1, 32'h40, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h80, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("post_flush_out_valid", 32'(out_valid), 32'd1);
    chk("post_flush_out_pc", out_pc, 32'h80);
    chk("post_flush_count", 32'(count), 32'd1);

    // Misaligned PC entry, then asynchronous reset in the middle of a cycle.
    flush = 1'b1;
    step();
    flush      = 1'b0;
    in_valid   = 1'b1;
    in_pc      = 32'h06;
    in_pcplus4 = 32'h0A;
    in_instr   = 32'h0000_0013;
    out_ready  = 1'b0;
    step();
    drive(1'b1, 32'h10, 1'b0);
    chk("misalign_flag", 32'(out_misalign), 32'd1);
    chk("misalign_pcplus4", out_pcplus4, 32'h0A);
    chk("misalign_instr", out_instr, 32'h13);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_out_instr", out_instr, 32'd0);
    chk("async_rst_misalign", 32'(out_misalign), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Randomized run against a plain queue model.
    model.delete();
    for (int c = 0; c < 400; c++) begin
      ent_t e;
      flush      = ($urandom_range(0, 19) == 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      in_pc      = $urandom;
      if ($urandom_range(0, 3) != 0) in_pc[1:0] = 2'b00;
      in_pcplus4 = in_pc + 32'd4;
      in_instr   = $urandom;
      m_ir = (model.size() != D);
      m_ov = (model.size() != 0);
      chk($sformatf("rnd%0d_count", c), 32'(count), 32'(model.size()));
      chk($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(m_ir));
      chk($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk($sformatf("rnd%0d_out_pc", c), out_pc, model[0].pc);
        chk($sformatf("rnd%0d_out_pcplus4", c), out_pcplus4, model[0].pcp4);
        chk($sformatf("rnd%0d_out_instr", c), out_instr, model[0].instr);
        chk($sformatf("rnd%0d_misalign", c), 32'(out_misalign), 32'(|model[0].pc[1:0]));
      end
      e.pc = in_pc; e.pcp4 = in_pcplus4; e.instr = in_instr;
      if (flush) begin
        model.delete();
      end else begin
        if (m_ov && out_ready) void'(model.pop_front());
        if (m_ir && in_valid) model.push_back(e);
      end
      step();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
